ft_byte_bridge: RTL and testbench

- Byte-stream adapter between the FT245-style FIFO bridge's user interface (BUS_WIDTH-wide words with byte enables, clk domain) and byte-oriented user logic.
- RX path unpacks each received word into its enabled bytes, lane 0 first.
- TX path packs user bytes into words, emitting partial words with correct byte enables on an explicit flush or an idle timeout.
- Sits directly on the bridge's ui_* ports; one clock domain.

---
 rtl/ft_byte_bridge.sv | 140 ++++++++++++++
 tb/tb_ft_byte_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_byte_bridge.sv
// ft_byte_bridge: byte-stream adapter between the FT FIFO bridge word interface and byte-oriented user logic.
// Revision 1.0
`default_nettype none

module ft_byte_bridge #(
  parameter int          BUS_WIDTH     = 16,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUS_WIDTH-1:0]   ft_dout,
  input  logic [BUS_WIDTH/8-1:0] ft_dout_be,
  input  logic                   ft_dout_empty,
  output logic                   ft_dout_get,
  output logic [BUS_WIDTH-1:0]   ft_din,
  output logic [BUS_WIDTH/8-1:0] ft_din_be,
  output logic                   ft_din_valid,
  input  logic                   ft_din_full,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   tx_flush
);

  localparam int            NB     = BUS_WIDTH / 8;
  localparam int            CW     = $clog2(NB + 1);
  localparam logic [CW-1:0] C_FULL = CW'(NB);
  localparam logic [CW-1:0] C_LAST = CW'(NB - 1);

  // RX path state
  logic [BUS_WIDTH-1:0] rx_word_q, rx_word_d;
  logic [NB-1:0]        rx_mask_q, rx_mask_d;
  logic [NB-1:0]        rx_low, rx_rest;
  logic                 rx_fire, rx_load;

  // TX path state
  logic [BUS_WIDTH-1:0] tx_acc_q, tx_acc_d, tx_acc_next;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d, tx_cnt_acc;
  logic [BUS_WIDTH-1:0] tx_out_q, tx_out_d;
  logic [NB-1:0]        tx_be_q, tx_be_d, tx_part_be;
  logic                 tx_pend_q, tx_pend_d;
  logic                 tx_flush_q, tx_flush_d;
  logic [15:0]          tx_idle_q, tx_idle_d;
  logic                 tx_free, tx_accept, tx_timeout, tx_full_move, tx_flush_move;

  always_comb begin
    rx_data = 8'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (rx_mask_q[i]) rx_data = rx_word_q[8*i +: 8];
    end
    rx_low   = rx_mask_q & (~rx_mask_q + 1'b1);
    rx_valid = (|rx_mask_q) && !rst;
    rx_fire  = rx_valid && rx_ready;
    rx_rest  = rx_fire ? (rx_mask_q & ~rx_low) : rx_mask_q;
    // Refill as soon as nothing is left after this cycle, so bytes stream without a bubble.
    rx_load     = (rx_rest == '0) && !ft_dout_empty && !rst;
    ft_dout_get = rx_load;
    rx_mask_d   = rx_load ? ft_dout_be : rx_rest;
    rx_word_d   = rx_load ? ft_dout : rx_word_q;
  end

  always_comb begin
    ft_din_valid = tx_pend_q && !ft_din_full && !rst;
    tx_free      = !tx_pend_q || ft_din_valid;
    tx_ready     = rst || (tx_cnt_q < C_LAST) || tx_free;
    tx_accept    = tx_valid && tx_ready;

    tx_acc_next = tx_acc_q;
    for (int i = 0; i < NB; i++) begin
      if (tx_accept && (tx_cnt_q == CW'(i))) tx_acc_next[8*i +: 8] = tx_data;
    end
    tx_cnt_acc = tx_cnt_q + CW'(tx_accept);

    tx_part_be = '0;
    for (int i = 0; i < NB; i++) begin
      tx_part_be[i] = (CW'(i) < tx_cnt_acc);
    end

    tx_idle_d = tx_idle_q;
    if (tx_accept || (tx_cnt_q == '0)) begin
      tx_idle_d = 16'd0;
    end else if (tx_idle_q != FLUSH_TIMEOUT) begin
      tx_idle_d = tx_idle_q + 16'd1;
    end
    tx_timeout = (FLUSH_TIMEOUT != 16'd0) && (tx_idle_d == FLUSH_TIMEOUT);

    // A flush request only sticks when there is at least one byte to send.
    tx_flush_d    = (tx_flush_q || tx_flush || tx_timeout) && (tx_cnt_acc != '0);
    tx_full_move  = (tx_cnt_acc == C_FULL);
    tx_flush_move = tx_flush_q && tx_free && (tx_cnt_acc != '0);

    tx_acc_d  = tx_acc_next;
    tx_cnt_d  = tx_cnt_acc;
    tx_out_d  = tx_out_q;
    tx_be_d   = tx_be_q;
    tx_pend_d = tx_pend_q && !ft_din_valid;
    if (tx_full_move || tx_flush_move) begin
      tx_out_d   = tx_acc_next;
      tx_be_d    = tx_part_be;
      tx_pend_d  = 1'b1;
      tx_acc_d   = '0;
      tx_cnt_d   = '0;
      tx_flush_d = 1'b0;
      tx_idle_d  = 16'd0;
    end

    ft_din    = tx_out_q;
    ft_din_be = tx_be_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_word_q  <= '0;
      rx_mask_q  <= '0;
      tx_acc_q   <= '0;
      tx_cnt_q   <= '0;
      tx_out_q   <= '0;
      tx_be_q    <= '0;
      tx_pend_q  <= 1'b0;
      tx_flush_q <= 1'b0;
      tx_idle_q  <= 16'd0;
    end else begin
      rx_word_q  <= rx_word_d;
      rx_mask_q  <= rx_mask_d;
      tx_acc_q   <= tx_acc_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_be_q    <= tx_be_d;
      tx_pend_q  <= tx_pend_d;
      tx_flush_q <= tx_flush_d;
      tx_idle_q  <= tx_idle_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ft_byte_bridge.sv
// tb_ft_byte_bridge: directed and randomized checks of ft_byte_bridge against a byte-stream reference model.
`default_nettype none

module tb_ft_byte_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ft_dout;
  logic [1:0]  ft_dout_be;
  logic        ft_dout_empty;
  logic        ft_dout_get;
  logic [15:0] ft_din;
  logic [1:0]  ft_din_be;
  logic        ft_din_valid;
  logic        ft_din_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_flush;

  always #5 clk = ~clk;

  ft_byte_bridge #(.BUS_WIDTH(16), .FLUSH_TIMEOUT(16'd4)) dut (
    .clk(clk), .rst(rst),
    .ft_dout(ft_dout), .ft_dout_be(ft_dout_be), .ft_dout_empty(ft_dout_empty), .ft_dout_get(ft_dout_get),
    .ft_din(ft_din), .ft_din_be(ft_din_be), .ft_din_valid(ft_din_valid), .ft_din_full(ft_din_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] rxq[$];    // bridge RX FIFO contents {be, data}
  logic [7:0]  exp_rx[$]; // bytes the consumer must see, in order
  logic [7:0]  rx_got[$];
  logic [7:0]  exp_tx[$]; // accepted bytes not yet written out
  logic [17:0] exp_w[$];  // exact words expected in directed TX steps
  bit          strict;
  int cyc = 0, pops = 0, rx_n = 0, first_rx_cyc = 0, last_rx_cyc = 0;
  int wr_n = 0, last_wr_cyc = 0, acc_n = 0, last_acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present the FIFO head, sample at negedge+1, update the model, advance.
  task automatic cycle();
    logic [17:0] w;
    logic [17:0] ew;
    if (rxq.size() != 0) begin
      ft_dout_empty = 1'b0;
      {ft_dout_be, ft_dout} = rxq[0];
    end else begin
      ft_dout_empty = 1'b1;
      ft_dout_be = '0;
      ft_dout = '0;
    end
    #1;
    check("get_when_empty", 32'(ft_dout_get & ft_dout_empty), 32'd0);
    if (rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
      else check("rx_data", 32'(rx_data), 32'(exp_rx[0]));
      if (rx_ready) begin
        if (exp_rx.size() != 0) void'(exp_rx.pop_front());
        rx_got.push_back(rx_data);
        if (rx_n == 0) first_rx_cyc = cyc;
        last_rx_cyc = cyc;
        rx_n++;
      end
    end
    if (ft_dout_get && !ft_dout_empty) begin
      w = rxq.pop_front();
      pops++;
      for (int i = 0; i < 2; i++) if (w[16+i]) exp_rx.push_back(w[8*i +: 8]);
    end
    if (ft_din_valid) begin
      wr_n++;
      last_wr_cyc = cyc;
      if (strict) begin
        if (exp_w.size() == 0) check("din_unexpected_write", 32'(ft_din_valid), 32'd0);
        else begin
          ew = exp_w.pop_front();
          check("din_word", 32'({ft_din_be, ft_din}), 32'(ew));
        end
      end else begin
        check("din_be_shape", 32'(ft_din_be == 2'b01 || ft_din_be == 2'b11), 32'd1);
        if (ft_din_be == 2'b01) check("din_unused_lane", 32'(ft_din[15:8]), 32'd0);
        for (int i = 0; i < 2; i++) begin
          if (ft_din_be[i]) begin
            if (exp_tx.size() == 0) check("din_extra_byte", 32'(ft_din_be[i]), 32'd0);
            else check("din_byte", 32'(ft_din[8*i +: 8]), 32'(exp_tx.pop_front()));
          end
        end
      end
    end
    if (tx_valid && tx_ready) begin
      exp_tx.push_back(tx_data);
      acc_n++;
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int a0;
    bit ok;
    ok = 1'b0;
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      a0 = acc_n;
      cycle();
      if (acc_n != a0) ok = 1'b1;
    end
    tx_valid = 1'b0;
    check("send_byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int bound);
    for (int k = 0; k < bound && wr_n < target; k++) cycle();
    check("write_count", 32'(wr_n), 32'(target));
  endtask

  initial begin
    logic [7:0] seq [6];
    int idx, a0, w0;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    strict = 1'b1;
    rst = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_flush = 1'b0;
    ft_din_full = 1'b0; ft_dout_empty = 1'b1; ft_dout = '0; ft_dout_be = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_dout_get", 32'(ft_dout_get), 32'd0);
    check("rst_din_valid", 32'(ft_din_valid), 32'd0);
    check("rst_din", 32'(ft_din), 32'd0);
    check("rst_din_be", 32'(ft_din_be), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);

    // RX: two full words stream out at one byte per cycle
    rx_ready = 1'b1;
    pops = 0; rx_n = 0; rx_got.delete();
    rxq.push_back({2'b11, 16'hBBAA});
    rxq.push_back({2'b11, 16'hDDCC});
    for (int k = 0; k < 20 && rx_n < 4; k++) cycle();
    repeat (3) cycle();
    check("rx1_bytes", 32'(rx_n), 32'd4);
    check("rx1_consecutive", 32'(last_rx_cyc - first_rx_cyc), 32'd3);
    check("rx1_pops", 32'(pops), 32'd2);
    if (rx_got.size() == 4) check("rx1_stream", {rx_got[0], rx_got[1], rx_got[2], rx_got[3]}, 32'hAABBCCDD);

    // RX: partial and empty byte enables
    pops = 0; rx_n = 0; rx_got.delete();
    rxq.push_back({2'b10, 16'h1234});
    rxq.push_back({2'b00, 16'h0000});
    rxq.push_back({2'b01, 16'h5678});
    for (int k = 0; k < 20 && (rx_n < 2 || rxq.size() != 0); k++) cycle();
    repeat (3) cycle();
    check("rx2_bytes", 32'(rx_n), 32'd2);
    check("rx2_pops", 32'(pops), 32'd3);
    if (rx_got.size() == 2) check("rx2_stream", 32'({rx_got[0], rx_got[1]}), 32'h1278);

    // TX: streamed bytes pack into full words
    w0 = wr_n;
    exp_w.push_back({2'b11, 16'h0201});
    exp_w.push_back({2'b11, 16'h0403});
    for (int i = 0; i < 4; i++) send_byte(seq[i]);
    wait_writes(w0 + 2, 20);
    check("tx_full_words_left", 32'(exp_w.size()), 32'd0);

    // TX: byte with flush in the same cycle, then a flush with nothing buffered
    w0 = wr_n;
    exp_w.push_back({2'b01, 16'h0055});
    tx_flush = 1'b1;
    send_byte(8'h55);
    tx_flush = 1'b0;
    wait_writes(w0 + 1, 10);
    check("flush_before_timeout", 32'((last_wr_cyc - last_acc_cyc) < 6), 32'd1);
    tx_flush = 1'b1;
    cycle();
    tx_flush = 1'b0;
    repeat (10) cycle();
    check("flush_empty_ignored", 32'(wr_n), 32'(w0 + 1));

    // TX: idle timeout flushes a lone byte after 4 idle cycles plus the transfer cycle
    w0 = wr_n;
    exp_w.push_back({2'b01, 16'h0077});
    send_byte(8'h77);
    wait_writes(w0 + 1, 12);
    check("timeout_latency", 32'(last_wr_cyc - last_acc_cyc), 32'd6);

    // TX: back-pressure from a full bridge FIFO
    w0 = wr_n;
    exp_w.push_back({2'b11, 16'h0201});
    exp_w.push_back({2'b11, 16'h0403});
    exp_w.push_back({2'b11, 16'h0605});
    ft_din_full = 1'b1;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      tx_data = seq[idx]; tx_valid = 1'b1; a0 = acc_n;
      cycle();
      if (acc_n != a0) idx++;
    end
    check("full_accepted", 32'(idx), 32'd3);
    check("full_tx_ready", 32'(tx_ready), 32'd0);
    check("full_no_write", 32'(wr_n), 32'(w0));
    ft_din_full = 1'b0;
    for (int k = 0; k < 30 && idx < 6; k++) begin
      tx_data = seq[idx]; tx_valid = 1'b1; a0 = acc_n;
      cycle();
      if (acc_n != a0) idx++;
    end
    tx_valid = 1'b0;
    wait_writes(w0 + 3, 20);
    check("full_words_left", 32'(exp_w.size()), 32'd0);

    // Reset with a partial TX word discards it
    w0 = wr_n;
    send_byte(8'h99);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (12) cycle();
    check("rst_mid_no_write", 32'(wr_n), 32'(w0));
    check("rst_mid_din_valid", 32'(ft_din_valid), 32'd0);

    // Randomized traffic on both paths against the byte-stream model
    strict = 1'b0;
    exp_tx.delete();
    for (int k = 0; k < 3000; k++) begin
      if (rxq.size() < 4 && $urandom_range(2) == 0)
        rxq.push_back({2'($urandom_range(3)), 16'($urandom)});
      rx_ready    = ($urandom_range(3) != 0);
      tx_valid    = ($urandom_range(2) != 0);
      tx_data     = 8'($urandom);
      tx_flush    = ($urandom_range(15) == 0);
      ft_din_full = ($urandom_range(3) == 0);
      cycle();
    end
    rx_ready = 1'b1; tx_valid = 1'b0; tx_flush = 1'b0; ft_din_full = 1'b0;
    for (int k = 0; k < 200 && (rxq.size() != 0 || exp_rx.size() != 0 || exp_tx.size() != 0); k++) cycle();
    check("rand_rxq_drained", 32'(rxq.size()), 32'd0);
    check("rand_rx_bytes_left", 32'(exp_rx.size()), 32'd0);
    check("rand_tx_bytes_left", 32'(exp_tx.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
